// File: rtl/host_bridge_32_16_pkg.sv
// host_bridge_32_16_pkg: shared FSM state type and bus widths for the 32-to-16 bridge
package host_bridge_32_16_pkg;
  localparam int HADDR_W = 30;
  localparam int BADDR_W = 31;
  localparam int HDATA_W = 32;
  localparam int BDATA_W = 16;
  localparam int HBE_W = 4;
  localparam int BBE_W = 2;
  typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_e;
endpackage

// File: rtl/host_bridge_32_16_if.sv
// host_bridge_32_16_if: host-side and memory-side signals of the bridge
interface host_bridge_32_16_if;
  import host_bridge_32_16_pkg::*;
  logic               h_cs;
  logic [HADDR_W-1:0] h_addr;
  logic [HDATA_W-1:0] h_wdata;
  logic               h_wr_en;
  logic [HBE_W-1:0]   h_bytesel;
  logic [HDATA_W-1:0] h_rdata;
  logic               h_compl;
  logic               b_access;
  logic [BADDR_W-1:0] b_addr;
  logic [BDATA_W-1:0] b_wdata;
  logic               b_wr_en;
  logic [BBE_W-1:0]   b_bytesel;
  logic [BDATA_W-1:0] b_rdata;
  logic               b_compl;
  modport slave (
    input  h_cs, h_addr, h_wdata, h_wr_en, h_bytesel, b_rdata, b_compl,
    output h_rdata, h_compl, b_access, b_addr, b_wdata, b_wr_en, b_bytesel
  );
  modport master (
    output h_cs, h_addr, h_wdata, h_wr_en, h_bytesel, b_rdata, b_compl,
    input  h_rdata, h_compl, b_access, b_addr, b_wdata, b_wr_en, b_bytesel
  );
endinterface

// File: rtl/host_bridge_32_16_addr_cs_decode.sv
// addr_cs_decode: combinational chip select for a byte-addressed window [address, address+size)
module addr_cs_decode
  import host_bridge_32_16_pkg::*;
#(
  parameter logic [31:0] address = 32'h0,
  parameter logic [31:0] size    = 32'h0
) (
  input  logic [HADDR_W-1:0] bus_addr,
  output logic               cs
);
  logic [31:0] byte_addr;
  logic [31:0] limit;
  assign byte_addr = {bus_addr, 2'b00};
  assign limit     = address + size;
  assign cs        = (byte_addr >= address) && (byte_addr < limit);
endmodule

// File: rtl/host_bridge_32_16.sv
// host_bridge_32_16: splits each 32-bit host access into two 16-bit memory transactions, low half first
module host_bridge_32_16
  import host_bridge_32_16_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  host_bridge_32_16_if.slave bus
);
  state_e               state_q, state_d;
  logic [HADDR_W-1:0]   addr_q, addr_d;
  logic [BDATA_W-1:0]   whi_q, whi_d;
  logic [BBE_W-1:0]     bhi_q, bhi_d;
  logic                 wr_q, wr_d;
  logic [HDATA_W-1:0]   rdata_q, rdata_d;
  logic [BADDR_W-1:0]   b_addr_q, b_addr_d;
  logic [BDATA_W-1:0]   b_wdata_q, b_wdata_d;
  logic                 b_wr_q, b_wr_d;
  logic [BBE_W-1:0]     b_bs_q, b_bs_d;
  logic                 b_access_q, b_access_d;
  logic                 h_compl_q, h_compl_d;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      whi_q      <= '0;
      bhi_q      <= '0;
      wr_q       <= 1'b0;
      rdata_q    <= '0;
      b_addr_q   <= '0;
      b_wdata_q  <= '0;
      b_wr_q     <= 1'b0;
      b_bs_q     <= '0;
      b_access_q <= 1'b0;
      h_compl_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      whi_q      <= whi_d;
      bhi_q      <= bhi_d;
      wr_q       <= wr_d;
      rdata_q    <= rdata_d;
      b_addr_q   <= b_addr_d;
      b_wdata_q  <= b_wdata_d;
      b_wr_q     <= b_wr_d;
      b_bs_q     <= b_bs_d;
      b_access_q <= b_access_d;
      h_compl_q  <= h_compl_d;
    end
  end
  // Only the upper halves are kept; the low half is issued straight from the host inputs.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    whi_d      = whi_q;
    bhi_d      = bhi_q;
    wr_d       = wr_q;
    rdata_d    = rdata_q;
    b_addr_d   = b_addr_q;
    b_wdata_d  = b_wdata_q;
    b_wr_d     = b_wr_q;
    b_bs_d     = b_bs_q;
    b_access_d = 1'b0;
    h_compl_d  = 1'b0;
    case (state_q)
      IDLE: if (bus.h_cs) begin
        addr_d     = bus.h_addr;
        whi_d      = bus.h_wdata[31:16];
        bhi_d      = bus.h_bytesel[3:2];
        wr_d       = bus.h_wr_en;
        b_addr_d   = {bus.h_addr, 1'b0};
        b_wdata_d  = bus.h_wdata[15:0];
        b_bs_d     = bus.h_bytesel[1:0];
        b_wr_d     = bus.h_wr_en;
        b_access_d = 1'b1;
        state_d    = LO;
      end
      LO: if (bus.b_compl) begin
        rdata_d[15:0] = wr_q ? rdata_q[15:0] : bus.b_rdata;
        b_addr_d      = {addr_q, 1'b1};
        b_wdata_d     = whi_q;
        b_bs_d        = bhi_q;
        b_access_d    = 1'b1;
        state_d       = HI;
      end
      HI: if (bus.b_compl) begin
        rdata_d[31:16] = wr_q ? rdata_q[31:16] : bus.b_rdata;
        h_compl_d      = 1'b1;
        state_d        = DONE;
      end
      default: state_d = IDLE;
    endcase
  end
  assign bus.h_rdata   = rdata_q;
  assign bus.h_compl   = h_compl_q;
  assign bus.b_access  = b_access_q;
  assign bus.b_addr    = b_addr_q;
  assign bus.b_wdata   = b_wdata_q;
  assign bus.b_wr_en   = b_wr_q;
  assign bus.b_bytesel = b_bs_q;
endmodule

// File: tb/tb_host_bridge_32_16.sv
// tb_host_bridge_32_16: directed vector table plus hand-written corner sequences for the bridge and decoder
module tb_host_bridge_32_16;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  host_bridge_32_16_if bus();
  host_bridge_32_16 dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  logic [29:0] dec_addr;
  logic cs_a, cs_z;
  addr_cs_decode #(.address(32'h2000_0000), .size(32'h0200_0000)) dec_a (.bus_addr(dec_addr), .cs(cs_a));
  addr_cs_decode #(.address(32'h2000_0000), .size(32'h0)) dec_z (.bus_addr(dec_addr), .cs(cs_z));
  always #5 clk = ~clk;
  int errors = 0;
  int checks = 0;
  int lat_lo, lat_hi, cnt, ncompl, nacc;
  logic pend = 1'b0;
  logic [15:0] rd_lo, rd_hi;
  logic [30:0] acc_addr [8];
  logic [15:0] acc_wdata [8];
  logic [1:0]  acc_bs [8];
  logic        acc_wr [8];
  typedef struct {
    logic [29:0] addr;
    logic [31:0] wdata;
    logic        wr;
    logic [3:0]  bs;
    int          llo, lhi;
    logic [15:0] rlo, rhi;
    logic [31:0] exp_rdata;
    int          exp_lat;
    logic [30:0] exp_a0, exp_a1;
    logic [15:0] exp_w0, exp_w1;
    logic [1:0]  exp_b0, exp_b1;
  } vec_t;
  vec_t tbl [4];
  typedef struct {
    logic [29:0] a;
    logic        cs;
  } dvec_t;
  dvec_t dtbl [5];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  // Memory-side slave: answers each b_access after the configured latency and logs the transaction.
  always @(negedge clk) begin
    bus.b_compl = 1'b0;
    if (!rst_n) pend = 1'b0;
    else begin
      if (bus.b_access) begin
        pend = 1'b1;
        cnt = bus.b_addr[0] ? lat_hi : lat_lo;
        if (nacc < 8) begin
          acc_addr[nacc] = bus.b_addr;
          acc_wdata[nacc] = bus.b_wdata;
          acc_bs[nacc] = bus.b_bytesel;
          acc_wr[nacc] = bus.b_wr_en;
        end
        nacc++;
      end
      if (pend) begin
        if (cnt == 0) begin
          bus.b_compl = 1'b1;
          bus.b_rdata = bus.b_addr[0] ? rd_hi : rd_lo;
          pend = 1'b0;
        end else cnt--;
      end
    end
    if (bus.h_compl) ncompl++;
  end
  task automatic run_vec(input vec_t v, input string tag);
    int got, nc0;
    got = -1;
    nacc = 0;
    lat_lo = v.llo; lat_hi = v.lhi; rd_lo = v.rlo; rd_hi = v.rhi;
    @(negedge clk);
    nc0 = ncompl;
    bus.h_cs = 1'b1; bus.h_addr = v.addr; bus.h_wdata = v.wdata;
    bus.h_wr_en = v.wr; bus.h_bytesel = v.bs;
    @(posedge clk); #1;
    bus.h_cs = 1'b0; bus.h_addr = ~v.addr; bus.h_wdata = ~v.wdata;
    bus.h_wr_en = ~v.wr; bus.h_bytesel = ~v.bs;
    for (int k = 1; k <= 20 && got < 0; k++) begin
      @(posedge clk); #1;
      if (bus.h_compl) got = k;
    end
    chk({tag, " compl latency"}, got, v.exp_lat);
    chk({tag, " h_rdata"}, bus.h_rdata, v.exp_rdata);
    @(posedge clk); #1;
    chk({tag, " h_compl one cycle"}, {31'b0, bus.h_compl}, 0);
    chk({tag, " compl count"}, ncompl - nc0, 1);
    chk({tag, " access count"}, nacc, 2);
    chk({tag, " addr lo"}, {1'b0, acc_addr[0]}, {1'b0, v.exp_a0});
    chk({tag, " addr hi"}, {1'b0, acc_addr[1]}, {1'b0, v.exp_a1});
    chk({tag, " wdata lo"}, {16'b0, acc_wdata[0]}, {16'b0, v.exp_w0});
    chk({tag, " wdata hi"}, {16'b0, acc_wdata[1]}, {16'b0, v.exp_w1});
    chk({tag, " bytesel lo/hi"}, {28'b0, acc_bs[1], acc_bs[0]}, {28'b0, v.exp_b1, v.exp_b0});
    chk({tag, " wr_en lo/hi"}, {30'b0, acc_wr[1], acc_wr[0]}, {30'b0, v.wr, v.wr});
  endtask
  task automatic chk_reset_outputs(input string tag);
    chk({tag, " h_rdata"}, bus.h_rdata, 0);
    chk({tag, " b_addr"}, {1'b0, bus.b_addr}, 0);
    chk({tag, " b_wdata/bs"}, {14'b0, bus.b_wdata, bus.b_bytesel}, 0);
    chk({tag, " strobes"}, {29'b0, bus.h_compl, bus.b_access, bus.b_wr_en}, 0);
  endtask
  initial begin
    int c1, c2, nc0;
    tbl[0] = '{30'h10, 32'h0, 1'b0, 4'hF, 1, 1, 16'hBEEF, 16'hDEAD, 32'hDEADBEEF, 4,
               31'h20, 31'h21, 16'h0, 16'h0, 2'b11, 2'b11};
    tbl[1] = '{30'h3, 32'h12345678, 1'b1, 4'b0110, 0, 2, 16'h0, 16'h0, 32'hDEADBEEF, 4,
               31'h6, 31'h7, 16'h5678, 16'h1234, 2'b10, 2'b01};
    tbl[2] = '{30'h3FFF_FFFF, 32'h0, 1'b0, 4'hF, 0, 0, 16'h1111, 16'h2222, 32'h22221111, 2,
               31'h7FFF_FFFE, 31'h7FFF_FFFF, 16'h0, 16'h0, 2'b11, 2'b11};
    tbl[3] = '{30'h0, 32'hAAAA5555, 1'b1, 4'b0000, 3, 0, 16'h0, 16'h0, 32'h22221111, 5,
               31'h0, 31'h1, 16'h5555, 16'hAAAA, 2'b00, 2'b00};
    dtbl[0] = '{30'h0800_0000, 1'b1};
    dtbl[1] = '{30'h087F_FFFF, 1'b1};
    dtbl[2] = '{30'h0880_0000, 1'b0};
    dtbl[3] = '{30'h07FF_FFFF, 1'b0};
    dtbl[4] = '{30'h0, 1'b0};
    ncompl = 0; nacc = 0; lat_lo = 0; lat_hi = 0; rd_lo = '0; rd_hi = '0; cnt = 0;
    bus.h_cs = 1'b0; bus.h_addr = '0; bus.h_wdata = '0; bus.h_wr_en = 1'b0; bus.h_bytesel = '0;
    bus.b_rdata = '0; bus.b_compl = 1'b0;
    dec_addr = '0;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs("reset");
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      dec_addr = dtbl[i].a;
      #1;
      chk($sformatf("decode cs[%0d]", i), {31'b0, cs_a}, {31'b0, dtbl[i].cs});
      chk($sformatf("decode size0[%0d]", i), {31'b0, cs_z}, 0);
    end
    for (int i = 0; i < 4; i++) run_vec(tbl[i], $sformatf("vec%0d", i));
    // Reset while the high half is outstanding.
    nacc = 0; lat_lo = 0; lat_hi = 6; rd_lo = 16'h3333; rd_hi = 16'h4444;
    @(negedge clk);
    bus.h_cs = 1'b1; bus.h_addr = 30'h20; bus.h_wr_en = 1'b0; bus.h_bytesel = 4'hF;
    @(posedge clk); #1;
    bus.h_cs = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("pre-reset in HI b_addr", {1'b0, bus.b_addr}, 32'h41);
    nc0 = ncompl;
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("async reset");
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    chk("no compl after reset", ncompl - nc0, 0);
    run_vec(tbl[0], "post-reset");
    // h_cs held across h_compl; host inputs change while in LO.
    nacc = 0; lat_lo = 2; lat_hi = 0; rd_lo = 16'h5555; rd_hi = 16'h6666;
    c1 = -1; c2 = -1;
    @(negedge clk);
    bus.h_cs = 1'b1; bus.h_addr = 30'h40; bus.h_wdata = 32'h0; bus.h_wr_en = 1'b0; bus.h_bytesel = 4'hF;
    @(posedge clk); #1;
    bus.h_addr = 30'h55; bus.h_wdata = 32'hCAFEF00D; bus.h_wr_en = 1'b1; bus.h_bytesel = 4'b1001;
    chk("LO ignores host b_addr", {1'b0, bus.b_addr}, 32'h80);
    for (int k = 1; k <= 20 && c1 < 0; k++) begin
      @(posedge clk); #1;
      if (bus.h_compl) c1 = k;
    end
    chk("held compl latency", c1, 4);
    chk("held h_rdata", bus.h_rdata, 32'h66665555);
    @(posedge clk); #1;
    chk("DONE no access", {30'b0, bus.h_compl, bus.b_access}, 0);
    @(posedge clk); #1;
    chk("rearm b_access", {31'b0, bus.b_access}, 1);
    chk("rearm b_addr", {1'b0, bus.b_addr}, 32'hAA);
    chk("rearm b_wdata", {16'b0, bus.b_wdata}, 32'hF00D);
    chk("rearm b_wr_en/bs", {29'b0, bus.b_wr_en, bus.b_bytesel}, 32'h5);
    bus.h_cs = 1'b0;
    for (int k = 1; k <= 20 && c2 < 0; k++) begin
      @(posedge clk); #1;
      if (bus.h_compl) c2 = k;
    end
    chk("second compl seen", {31'b0, c2 > 0}, 1);
    chk("write keeps h_rdata", bus.h_rdata, 32'h66665555);
    chk("held access count", nacc, 4);
    chk("held hi half addr", {1'b0, acc_addr[1]}, 32'h81);
    chk("held hi half wr", {31'b0, acc_wr[1]}, 0);
    chk("second hi wdata", {16'b0, acc_wdata[3]}, 32'hCAFE);
    chk("second hi bs", {30'b0, acc_bs[3]}, 32'h2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
